ldl_rr_req_queue: RTL and testbench
===================================

Name: ldl_rr_req_queue

Overview:
- Per-requester ingress queue bank that sits directly upstream of the round-robin priority arbiter.
- Accepts a stream of tagged requests, each carrying a destination requester index and a class-of-service (COS) value.
- Holds each request in the FIFO of its requester index.
- Presents each FIFO's head-of-line request and COS to the arbiter as req/icos, and pops a FIFO when the arbiter returns ack for that bit.

Parameters:
- BIN_WIDTH, 3, width of requester index; REQ_WIDTH = 1 << BIN_WIDTH queues.
- COS_WIDTH, 2, width of the class-of-service tag stored per entry.
- DEPTH_WIDTH, 2, log2 of per-queue depth; DEPTH = 1 << DEPTH_WIDTH entries per queue.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- push_valid  input  1  ingress request present.
- push_bin  input  BIN_WIDTH  target queue index.
- push_cos  input  COS_WIDTH  COS tag of ingress request.
- push_ready  output  1  ingress accept; transfer occurs when push_valid && push_ready.
- req  output  REQ_WIDTH  bit i = queue i non-empty; feeds arbiter req.
- icos  output  REQ_WIDTH x COS_WIDTH  packed array; element i = head-of-line COS of queue i, 0 when queue i is empty.
- ack  input  REQ_WIDTH  pop strobes from arbiter; bit i pops queue i.
- full  output  REQ_WIDTH  bit i = queue i holds DEPTH entries.
- occupancy  output  BIN_WIDTH+DEPTH_WIDTH+1  total entries across all queues.

Behaviour:
- Storage: per queue, a DEPTH x COS_WIDTH array, a read pointer, a write pointer (DEPTH_WIDTH bits, natural wrap) and a count (DEPTH_WIDTH+1 bits, range 0..DEPTH).
- Reset (rst == 0 at rising edge): all pointers, counts and occupancy go to 0. Storage contents are don't-care.
- Output values under reset: req = 0, icos = all 0, full = 0, push_ready = 1 (when push_bin targets an empty queue), occupancy = 0.
- Reset mid-operation discards all queued entries.
- push_ready = ~full[push_bin]. It is combinational from registered state and push_bin only; there is no path from ack.
- Push: on a rising edge with push_valid && push_ready:
  - write push_cos at wptr[push_bin];
  - increment wptr[push_bin] and count[push_bin].
- Pop: on a rising edge with ack[i] && req[i]:
  - increment rptr[i];
  - decrement count[i].
- ack[i] while req[i] == 0 is ignored: no state change, no pointer underflow.
- ack may be multi-hot. Every set bit pops its own queue independently in the same cycle.
- Simultaneous push and pop on the same queue:
  - count unchanged, both pointers advance;
  - allowed whenever the queue is not full.
  - If the queue is full, the push is refused (push_ready = 0) even if ack pops it that cycle.
- req[i] = (count[i] != 0). icos[i] = mem_i[rptr[i]] when req[i], else 0. Both are combinational from registers.
- Latency:
  - An entry pushed at edge k is visible on req/icos from edge k onward (next cycle), i.e. 1-cycle push-to-request.
  - A pop at edge k exposes the next entry, or req[i] = 0, immediately after edge k.
- FIFO order is preserved per queue. There is no ordering guarantee across queues; that is the arbiter's job.
- full[i] = (count[i] == DEPTH).
- occupancy is registered: it is updated each edge by +1 for an accepted push and -popcount(ack & req) for pops, and never wraps.
- Pointer wrap: wptr/rptr roll over from DEPTH-1 to 0. count alone distinguishes full from empty.

Test Plan:
- Reset/idle: hold rst = 0 for 2 cycles, then release with push_valid = 0 -> req = 0x00, icos all 0, full = 0x00, occupancy = 0, push_ready = 1.
- Single push/pop: push bin = 5, cos = 2 -> next cycle req = 0x20, icos[5] = 2, occupancy = 1. Pulse ack = 0x20 -> following cycle req = 0x00, icos[5] = 0, occupancy = 0.
- Fill and FIFO order: push bin = 3 with cos 0,1,2,3 on consecutive cycles -> full = 0x08, push_ready = 0 for bin 3, a fifth push is not accepted. Repeated ack = 0x08 yields icos[3] sequence 0,1,2,3, then req[3] = 0.
- Full with simultaneous pop: queue 3 full, push bin = 3 and ack = 0x08 in the same cycle -> push refused, count drops to 3, full[3] = 0 next cycle.
- Multi-hot pop and spurious ack: queues 0, 2, 7 each hold one entry, apply ack = 0xFF -> req = 0x00, occupancy drops by exactly 3, no underflow on empty queues (next push to bin 1 shows icos[1] correct).
- Wrap and reset mid-run: push/pop bin 0 ten times (pointers wrap twice) with cos = i & 3 -> icos[0] tracks each value. Assert rst = 0 with 6 entries queued -> next cycle req = 0x00, occupancy = 0.

Source files
------------

// File: rtl/ldl_rr_req_queue_if.sv
// Handshake bundle between the ingress/arbiter side and the queue bank.
// master drives push_* and ack; slave returns push_ready, req, icos, full, occupancy.
interface ldl_rr_req_queue_if #(
    parameter int BIN_WIDTH   = 3,
    parameter int COS_WIDTH   = 2,
    parameter int DEPTH_WIDTH = 2
);
    localparam int REQ_WIDTH = 1 << BIN_WIDTH;
    localparam int OCC_WIDTH = BIN_WIDTH + DEPTH_WIDTH + 1;

    logic                                 push_valid;
    logic [BIN_WIDTH-1:0]                 push_bin;
    logic [COS_WIDTH-1:0]                 push_cos;
    logic                                 push_ready;
    logic [REQ_WIDTH-1:0]                 req;
    logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] icos;
    logic [REQ_WIDTH-1:0]                 ack;
    logic [REQ_WIDTH-1:0]                 full;
    logic [OCC_WIDTH-1:0]                 occupancy;

    modport master (
        output push_valid, push_bin, push_cos, ack,
        input  push_ready, req, icos, full, occupancy
    );

    modport slave (
        input  push_valid, push_bin, push_cos, ack,
        output push_ready, req, icos, full, occupancy
    );
endinterface

// File: rtl/ldl_rr_req_queue.sv
// Per-requester ingress FIFO bank feeding a round-robin arbiter.
// Ports: clk, rst (sync active-low), q (slave: push handshake, req/icos/ack, full, occupancy).
module ldl_rr_req_queue #(
    parameter int BIN_WIDTH   = 3,
    parameter int COS_WIDTH   = 2,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    ldl_rr_req_queue_if.slave  q
);
    localparam int REQ_WIDTH = 1 << BIN_WIDTH;
    localparam int DEPTH     = 1 << DEPTH_WIDTH;
    localparam int CNT_W     = DEPTH_WIDTH + 1;
    localparam int OCC_W     = BIN_WIDTH + DEPTH_WIDTH + 1;

    logic [COS_WIDTH-1:0]   mem  [REQ_WIDTH][DEPTH];
    logic [DEPTH_WIDTH-1:0] rptr [REQ_WIDTH];
    logic [DEPTH_WIDTH-1:0] wptr [REQ_WIDTH];
    logic [CNT_W-1:0]       cnt  [REQ_WIDTH];
    logic [OCC_W-1:0]       occ;

    logic [REQ_WIDTH-1:0]                 req_v;
    logic [REQ_WIDTH-1:0]                 full_v;
    logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] icos_v;
    logic [REQ_WIDTH-1:0]                 push_hit;
    logic [REQ_WIDTH-1:0]                 pop_hit;
    logic [OCC_W-1:0]                     npop;
    logic                                 push_ok;

    always_comb begin
        req_v  = '0;
        full_v = '0;
        icos_v = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            req_v[i]  = (cnt[i] != '0);
            full_v[i] = (cnt[i] == CNT_W'(DEPTH));
            if (req_v[i])
                icos_v[i] = mem[i][rptr[i]];
        end
    end

    // Fullness is judged on the registered count, so a same-cycle
    // pop never opens room for a push into a full queue.
    assign push_ok = q.push_valid && !full_v[q.push_bin];

    always_comb begin
        push_hit = '0;
        pop_hit  = q.ack & req_v;
        npop     = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            push_hit[i] = push_ok && (q.push_bin == BIN_WIDTH'(i));
            npop        = npop + OCC_W'(pop_hit[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (push_hit[i])
                mem[i][wptr[i]] <= q.push_cos;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                rptr[i] <= '0;
                wptr[i] <= '0;
                cnt[i]  <= '0;
            end
            occ <= '0;
        end else begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                if (push_hit[i])
                    wptr[i] <= wptr[i] + 1'b1;
                if (pop_hit[i])
                    rptr[i] <= rptr[i] + 1'b1;
                case ({push_hit[i], pop_hit[i]})
                    2'b10:   cnt[i] <= cnt[i] + 1'b1;
                    2'b01:   cnt[i] <= cnt[i] - 1'b1;
                    default: cnt[i] <= cnt[i];
                endcase
            end
            occ <= occ + OCC_W'(push_ok) - npop;
        end
    end

    assign q.push_ready = ~full_v[q.push_bin];
    assign q.req        = req_v;
    assign q.icos       = icos_v;
    assign q.full       = full_v;
    assign q.occupancy  = occ;
endmodule

// File: tb/tb_ldl_rr_req_queue.sv
// Randomised and directed bench for the per-requester queue bank.
// Queue-based reference model, per-cycle compare plus literal spot checks.
module tb_ldl_rr_req_queue;
    localparam int BW = 3;
    localparam int CW = 2;
    localparam int DW = 2;
    localparam int NQ = 1 << BW;
    localparam int DEPTH = 1 << DW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    logic [CW-1:0] mq [NQ][$];

    ldl_rr_req_queue_if #(.BIN_WIDTH(BW), .COS_WIDTH(CW), .DEPTH_WIDTH(DW)) q ();

    ldl_rr_req_queue #(
        .BIN_WIDTH(BW), .COS_WIDTH(CW), .DEPTH_WIDTH(DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain per-bin queues, updated on each rising edge.
    always @(posedge clk) begin
        logic [CW-1:0] tmp;
        bit acc;
        if (!rst) begin
            for (int i = 0; i < NQ; i++) mq[i].delete();
        end else begin
            acc = q.push_valid && (mq[q.push_bin].size() < DEPTH);
            for (int i = 0; i < NQ; i++)
                if (q.ack[i] && mq[i].size() > 0) tmp = mq[i].pop_front();
            if (acc) mq[q.push_bin].push_back(q.push_cos);
        end
    end

    // Compare process: all outputs every cycle, mid low phase.
    always @(negedge clk) begin
        logic [NQ-1:0] e_req, e_full;
        logic [NQ-1:0][CW-1:0] e_icos;
        int e_occ;
        #2;
        if (chk_en) begin
            e_req = '0; e_full = '0; e_icos = '0; e_occ = 0;
            for (int i = 0; i < NQ; i++) begin
                e_occ += mq[i].size();
                if (mq[i].size() > 0) begin
                    e_req[i] = 1'b1;
                    e_icos[i] = mq[i][0];
                end
                if (mq[i].size() == DEPTH) e_full[i] = 1'b1;
            end
            chk("req", 32'(q.req), 32'(e_req));
            chk("icos", 32'(q.icos), 32'(e_icos));
            chk("full", 32'(q.full), 32'(e_full));
            chk("occ", 32'(q.occupancy), e_occ);
            chk("push_ready", 32'(q.push_ready),
                32'(mq[q.push_bin].size() < DEPTH));
        end
    end

    task automatic drive(input bit r, input bit v, input int b,
                         input int c, input logic [NQ-1:0] a);
        @(negedge clk);
        rst          = r;
        q.push_valid = v;
        q.push_bin   = BW'(b);
        q.push_cos   = CW'(c);
        q.ack        = a;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 0, 0, '0);
    endtask

    initial begin
        q.push_valid = 1'b0;
        q.push_bin   = '0;
        q.push_cos   = '0;
        q.ack        = '0;

        drive(1'b0, 1'b0, 0, 0, '0);
        drive(1'b0, 1'b0, 0, 0, '0);
        idle();
        chk_en = 1'b1;
        #3;
        chk("rst_req", 32'(q.req), 0);
        chk("rst_icos", 32'(q.icos), 0);
        chk("rst_full", 32'(q.full), 0);
        chk("rst_occ", 32'(q.occupancy), 0);
        chk("rst_pr", 32'(q.push_ready), 1);

        drive(1'b1, 1'b1, 5, 2, '0);
        idle(); #3;
        chk("sp_req", 32'(q.req), 32'h20);
        chk("sp_icos5", 32'(q.icos[5]), 2);
        chk("sp_occ", 32'(q.occupancy), 1);
        drive(1'b1, 1'b0, 0, 0, 8'h20);
        idle(); #3;
        chk("sp_req0", 32'(q.req), 0);
        chk("sp_icos0", 32'(q.icos[5]), 0);
        chk("sp_occ0", 32'(q.occupancy), 0);

        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 3, k, '0);
        idle(); #3;
        chk("fill_full", 32'(q.full), 32'h08);
        drive(1'b1, 1'b1, 3, 0, '0); #3;
        chk("fill_pr", 32'(q.push_ready), 0);
        idle(); #3;
        chk("fill_occ", 32'(q.occupancy), 4);
        drive(1'b1, 1'b1, 3, 1, 8'h08);
        idle(); #3;
        chk("fp_full", 32'(q.full), 0);
        chk("fp_occ", 32'(q.occupancy), 3);
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 1'b0, 0, 0, 8'h08); #3;
            chk("fifo_icos3", 32'(q.icos[3]), k);
        end
        idle(); #3;
        chk("fifo_empty", 32'(q.req), 0);

        drive(1'b1, 1'b1, 0, 1, '0);
        drive(1'b1, 1'b1, 2, 2, '0);
        drive(1'b1, 1'b1, 7, 3, '0);
        idle(); #3;
        chk("mh_req", 32'(q.req), 32'h85);
        drive(1'b1, 1'b0, 0, 0, 8'hFF);
        idle(); #3;
        chk("mh_req0", 32'(q.req), 0);
        chk("mh_occ", 32'(q.occupancy), 0);
        drive(1'b1, 1'b1, 1, 3, '0);
        idle(); #3;
        chk("mh_icos1", 32'(q.icos[1]), 3);
        drive(1'b1, 1'b0, 0, 0, 8'h02);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 0, i & 3, '0);
            idle(); #3;
            chk("wrap_icos0", 32'(q.icos[0]), i & 3);
            drive(1'b1, 1'b0, 0, 0, 8'h01);
        end
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, i, i, '0);
        idle(); #3;
        chk("pre_rst_occ", 32'(q.occupancy), 6);
        drive(1'b0, 1'b0, 0, 0, '0);
        idle(); #3;
        chk("mid_rst_req", 32'(q.req), 0);
        chk("mid_rst_occ", 32'(q.occupancy), 0);

        for (int n = 0; n < 3000; n++) begin
            bit r;
            int b;
            r = ($urandom % 250) != 0;
            b = ($urandom % 3 == 0) ? int'($urandom % 3) : int'($urandom % NQ);
            drive(r, ($urandom % 4) != 0, b, int'($urandom % 4),
                  NQ'($urandom & $urandom & $urandom));
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
